// File: rtl/cordic_cos_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC cosine core between NUM_REQ requesters.
// A tag/oor tracking pipe follows the core, and each requester has a one-entry response buffer.
module cordic_cos_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned CORE_LATENCY = 17,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ*DATA_W-1:0] resp_data,
  output logic [NUM_REQ-1:0]        resp_oor,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_dataa,
  input  logic [DATA_W-1:0]         core_result,
  output logic                      idle
);

  localparam int unsigned TW  = $clog2(NUM_REQ);
  localparam int unsigned LAT = CORE_LATENCY;
  localparam logic signed [DATA_W-1:0] HALF_PI = DATA_W'(32'h6487ED51);

  logic                     rdy_q;
  logic [TW-1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       busy_q, busy_d;
  logic [LAT:0]             trk_v_q, trk_v_d;
  logic [LAT:0]             trk_oor_q, trk_oor_d;
  logic [TW-1:0]            trk_tag_q [LAT+1];
  logic [TW-1:0]            trk_tag_d [LAT+1];
  logic [NUM_REQ-1:0]       rv_q, rv_d;
  logic [NUM_REQ-1:0]       roor_q, roor_d;
  logic [DATA_W-1:0]        rdata_q [NUM_REQ];
  logic [DATA_W-1:0]        rdata_d [NUM_REQ];

  logic [NUM_REQ-1:0]       elig;
  logic                     gnt_any;
  logic [TW-1:0]            gnt_idx;
  logic signed [DATA_W-1:0] gnt_angle;
  logic                     gnt_oor;
  logic                     issue;
  int unsigned              cand;

  // Round-robin search starting just after the last granted index; gated until out of reset.
  always_comb begin
    elig    = req_valid & ~busy_q & {NUM_REQ{rdy_q}};
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_any && (|(elig & (NUM_REQ'(1) << cand)))) begin
        gnt_any = 1'b1;
        gnt_idx = TW'(cand);
      end
    end
    gnt_angle  = $signed(req_data[32'(gnt_idx)*DATA_W +: DATA_W]);
    gnt_oor    = (gnt_angle > HALF_PI) || (gnt_angle < -HALF_PI);
    issue      = gnt_any;
    req_ready  = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    core_dataa = gnt_any ? gnt_angle : '0;
    core_start = issue | (|trk_v_q[LAT-1:0]);
    idle       = ~(|trk_v_q) & ~(|busy_q) & ~(|rv_q);
  end

  // Next state: response handshake, capture of the final stage, pipe advance and issue.
  always_comb begin
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    trk_v_d   = trk_v_q;
    trk_oor_d = trk_oor_q;
    trk_tag_d = trk_tag_q;
    rv_d      = rv_q;
    roor_d    = roor_q;
    rdata_d   = rdata_q;

    busy_d = busy_d & ~(rv_q & resp_ready);
    rv_d   = rv_d & ~(rv_q & resp_ready);

    // busy[tag] keeps the target buffer empty, so capture never has to wait.
    if (trk_v_q[LAT]) begin
      rv_d[trk_tag_q[LAT]]    = 1'b1;
      roor_d[trk_tag_q[LAT]]  = trk_oor_q[LAT];
      rdata_d[trk_tag_q[LAT]] = core_result;
      trk_v_d[LAT]            = 1'b0;
    end

    if (core_start) begin
      for (int k = int'(LAT); k >= 1; k--) begin
        trk_v_d[k]   = trk_v_q[k-1];
        trk_oor_d[k] = trk_oor_q[k-1];
        trk_tag_d[k] = trk_tag_q[k-1];
      end
      trk_v_d[0]   = issue;
      trk_oor_d[0] = gnt_oor;
      trk_tag_d[0] = gnt_idx;
    end

    if (issue) begin
      busy_d[gnt_idx] = 1'b1;
      ptr_d           = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      ptr_q     <= TW'(NUM_REQ - 1);
      busy_q    <= '0;
      trk_v_q   <= '0;
      trk_oor_q <= '0;
      rv_q      <= '0;
      roor_q    <= '0;
      for (int k = 0; k <= int'(LAT); k++) trk_tag_q[k] <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) rdata_q[i] <= '0;
    end else begin
      rdy_q     <= 1'b1;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      trk_v_q   <= trk_v_d;
      trk_oor_q <= trk_oor_d;
      trk_tag_q <= trk_tag_d;
      rv_q      <= rv_d;
      roor_q    <= roor_d;
      rdata_q   <= rdata_d;
    end
  end

  assign resp_valid = rv_q;
  assign resp_oor   = roor_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
    assign resp_data[i*DATA_W +: DATA_W] = rdata_q[i];
  end

endmodule

// File: tb/tb_cordic_cos_arbiter.sv
// Bench for cordic_cos_arbiter: behavioural cosine core, per-requester scoreboard,
// a vector table for single ops and hand-written multi-cycle sequences.
module tb_cordic_cos_arbiter;
  localparam int unsigned NR  = 3;
  localparam int unsigned LAT = 17;
  localparam int unsigned DW  = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_oor, resp_ready;
  logic [NR*DW-1:0] req_data, resp_data;
  logic             core_start, idle;
  logic [DW-1:0]    core_dataa, core_result;

  always #5 clk = ~clk;

  cordic_cos_arbiter #(.NUM_REQ(NR), .CORE_LATENCY(LAT), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_oor(resp_oor),
    .resp_ready(resp_ready),
    .core_start(core_start), .core_dataa(core_dataa), .core_result(core_result),
    .idle(idle)
  );

  function automatic real ang_rad(input logic [DW-1:0] a);
    return $itor($signed(a)) / 1073741824.0;
  endfunction

  function automatic logic [DW-1:0] cos_q30(input logic [DW-1:0] a);
    real c;
    c = $cos(ang_rad(a));
    return DW'($rtoi(c * 1073741824.0));
  endfunction

  function automatic bit is_oor(input logic [DW-1:0] a);
    real r;
    r = ang_rad(a);
    if (r < 0.0) r = -r;
    return r > ang_rad(32'h6487ED51);
  endfunction

  function automatic longint adiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d < 0) ? -d : d;
  endfunction

  // Behavioural core: never reset, advances only on core_start, small fixed error on the output.
  bit [DW-1:0] core_pipe [LAT+1];
  always @(posedge clk) begin
    if (core_start === 1'b1) begin
      for (int k = LAT; k > 0; k--) core_pipe[k] <= core_pipe[k-1];
      core_pipe[0] <= core_dataa;
    end
  end
  assign core_result = cos_q30(core_pipe[LAT]) + DW'(3);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] angle;
    logic [DW-1:0] exp_res;
    bit            exp_oor;
  } sb_t;

  sb_t sbq [NR][$];
  int  resp_cnt [NR];

  // Scoreboard: push on issue, pop and compare on response handshake, flush on reset.
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset_n !== 1'b1) begin
      for (int i = 0; i < NR; i++) sbq[i].delete();
    end else begin
      chk("grant_onehot", $onehot0(req_ready), 64'(req_ready), 64'(0));
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) chk("no_grant_while_outstanding", sbq[i].size() == 0, 64'(sbq[i].size()), 64'(0));
        if (resp_valid[i]) chk("resp_has_issue", sbq[i].size() != 0, 64'(i), 64'(0));
        if (resp_valid[i] && resp_ready[i] && sbq[i].size() != 0) begin
          e = sbq[i].pop_front();
          resp_cnt[i]++;
          chk("sb_resp_data", adiff(resp_data[i*DW +: DW], e.exp_res) <= 16,
              64'(resp_data[i*DW +: DW]), 64'(e.exp_res));
          chk("sb_resp_oor", resp_oor[i] == e.exp_oor, 64'(resp_oor[i]), 64'(e.exp_oor));
        end
        if (req_valid[i] && req_ready[i]) begin
          e.angle   = req_data[i*DW +: DW];
          e.exp_res = cos_q30(e.angle);
          e.exp_oor = is_oor(e.angle);
          sbq[i].push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(name, idle === 1'b1, 64'(idle), 64'(1));
  endtask

  typedef struct {
    int            req;
    logic [DW-1:0] angle;
    logic [DW-1:0] exp_res;
    bit            exp_oor;
  } vec_t;

  vec_t tbl [7];

  // Single op: grant at once, response exactly LAT+1 cycles after the issue edge.
  task automatic run_vec(input vec_t v);
    int n;
    req_valid = '0;
    resp_ready = '0;
    req_data[v.req*DW +: DW] = v.angle;
    req_valid[v.req] = 1'b1;
    @(negedge clk);
    chk("tbl_req_ready", req_ready == (NR'(1) << v.req), 64'(req_ready), 64'(NR'(1) << v.req));
    tick();
    req_valid = '0;
    n = 0;
    while (!resp_valid[v.req] && n < 100) begin
      tick();
      n++;
    end
    chk("tbl_latency", n == int'(LAT) + 1, 64'(n), 64'(LAT + 1));
    chk("tbl_resp_data", adiff(resp_data[v.req*DW +: DW], v.exp_res) <= 16,
        64'(resp_data[v.req*DW +: DW]), 64'(v.exp_res));
    chk("tbl_resp_oor", resp_oor[v.req] == v.exp_oor, 64'(resp_oor[v.req]), 64'(v.exp_oor));
    resp_ready[v.req] = 1'b1;
    tick();
    resp_ready = '0;
    chk("tbl_resp_cleared", resp_valid == '0, 64'(resp_valid), 64'(0));
    chk("tbl_idle_after", idle == 1'b1, 64'(idle), 64'(1));
  endtask

  initial begin
    int   c0, c1, c2;
    logic seen;

    tbl[0] = '{0, 32'h0000_0000, 32'h4000_0000, 1'b0};
    tbl[1] = '{0, 32'h3243_F6A8, 32'h2D41_3CCD, 1'b0};
    tbl[2] = '{1, 32'h7000_0000, cos_q30(32'h7000_0000), 1'b1};
    tbl[3] = '{1, 32'h6487_ED51, 32'h0000_0000, 1'b0};
    tbl[4] = '{2, 32'h9B78_12AF, 32'h0000_0000, 1'b0};
    tbl[5] = '{2, 32'h8000_0000, cos_q30(32'h8000_0000), 1'b1};
    tbl[6] = '{0, 32'hCDBC_0958, 32'h2D41_3CCD, 1'b0};

    // Reset state with every input active.
    reset_n    = 1'b0;
    req_valid  = '1;
    resp_ready = '1;
    req_data   = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    repeat (3) tick();
    chk("rst_req_ready", req_ready == '0, 64'(req_ready), 64'(0));
    chk("rst_core_start", core_start == 1'b0, 64'(core_start), 64'(0));
    chk("rst_core_dataa", core_dataa == '0, 64'(core_dataa), 64'(0));
    chk("rst_idle", idle == 1'b1, 64'(idle), 64'(1));
    chk("rst_resp_valid", resp_valid == '0, 64'(resp_valid), 64'(0));
    chk("rst_resp_oor", resp_oor == '0, 64'(resp_oor), 64'(0));
    chk("rst_resp_data", resp_data == '0, 64'(resp_data[63:0]), 64'(0));
    req_valid = '0;
    resp_ready = '0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Two requesters contending: 0 then 1, then neither until responses drain.
    do_reset();
    req_data[0*DW +: DW] = 32'h1000_0000;
    req_data[1*DW +: DW] = 32'hF000_0000;
    req_valid  = 3'b011;
    resp_ready = 3'b011;
    c0 = resp_cnt[0];
    c1 = resp_cnt[1];
    @(negedge clk);
    chk("rr_first", req_ready == 3'b001, 64'(req_ready), 64'(3'b001));
    tick();
    @(negedge clk);
    chk("rr_second", req_ready == 3'b010, 64'(req_ready), 64'(3'b010));
    tick();
    @(negedge clk);
    chk("rr_both_busy", req_ready == 3'b000, 64'(req_ready), 64'(3'b000));
    repeat (60) tick();
    chk("rr_req0_served", resp_cnt[0] - c0 >= 2, 64'(resp_cnt[0] - c0), 64'(2));
    chk("rr_req1_served", resp_cnt[1] - c1 >= 2, 64'(resp_cnt[1] - c1), 64'(2));
    req_valid  = '0;
    resp_ready = '1;
    wait_idle("rr_drain");

    // Held response on requester 0 while requester 1 keeps being served.
    do_reset();
    req_data[0*DW +: DW] = 32'h3243_F6A8;
    req_valid  = 3'b001;
    resp_ready = 3'b010;
    @(negedge clk);
    chk("hold_grant0", req_ready == 3'b001, 64'(req_ready), 64'(3'b001));
    tick();
    req_data[0*DW +: DW] = 32'h0000_0000;
    req_valid = 3'b011;
    c1 = resp_cnt[1];
    for (int n = 0; n < 40; n++) begin
      req_data[1*DW +: DW] = 32'($urandom_range(32'h6000_0000));
      tick();
    end
    chk("hold_resp_valid", resp_valid[0] == 1'b1, 64'(resp_valid[0]), 64'(1));
    chk("hold_resp_data", adiff(resp_data[0 +: DW], 32'h2D41_3CCD) <= 16,
        64'(resp_data[0 +: DW]), 64'(32'h2D41_3CCD));
    chk("hold_req1_served", resp_cnt[1] - c1 >= 1, 64'(resp_cnt[1] - c1), 64'(1));
    req_valid = 3'b001;
    resp_ready = 3'b011;
    @(negedge clk);
    chk("reissue_not_same_cycle", req_ready[0] == 1'b0, 64'(req_ready[0]), 64'(0));
    tick();
    resp_ready = 3'b010;
    @(negedge clk);
    chk("reissue_next_cycle", req_ready == 3'b001, 64'(req_ready), 64'(3'b001));
    tick();
    req_valid  = '0;
    resp_ready = '1;
    wait_idle("hold_drain");

    // Reset in the middle of an op flushes it.
    do_reset();
    req_data[0*DW +: DW] = 32'h0000_0000;
    req_valid = 3'b001;
    @(negedge clk);
    tick();
    req_valid = '0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("flush_resp_valid", resp_valid == '0, 64'(resp_valid), 64'(0));
    chk("flush_idle", idle == 1'b1, 64'(idle), 64'(1));
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      seen = seen | (|resp_valid) | ~idle;
    end
    chk("flush_no_response", seen == 1'b0, 64'(seen), 64'(0));

    // All requesters busy with random response backpressure.
    do_reset();
    c0 = resp_cnt[0];
    c1 = resp_cnt[1];
    c2 = resp_cnt[2];
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      req_valid  = '1;
      resp_ready = NR'($urandom);
      tick();
    end
    req_valid  = '0;
    resp_ready = '1;
    wait_idle("rand_drain");
    chk("rand_req0_served", resp_cnt[0] > c0, 64'(resp_cnt[0] - c0), 64'(1));
    chk("rand_req1_served", resp_cnt[1] > c1, 64'(resp_cnt[1] - c1), 64'(1));
    chk("rand_req2_served", resp_cnt[2] > c2, 64'(resp_cnt[2] - c2), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
